// File: rtl/general_register_file_pkg.sv
// Shared decode definitions for the general-purpose register file.
package general_register_file_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned SIZE_W   = 2;
    localparam int unsigned SHIFT_W  = 5;

    // Resolved operand size as delivered by the register decoder.
    typedef enum logic [SIZE_W-1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_WORD  = 2'b01,
        SIZE_DWORD = 2'b10,
        SIZE_RSVD  = 2'b11
    } size_e;

    localparam logic [IDX_W-1:0] REG_EAX = 3'd0;
    localparam logic [IDX_W-1:0] REG_ECX = 3'd1;
    localparam logic [IDX_W-1:0] REG_EDX = 3'd2;
    localparam logic [IDX_W-1:0] REG_EBX = 3'd3;
    localparam logic [IDX_W-1:0] REG_ESP = 3'd4;
    localparam logic [IDX_W-1:0] REG_EBP = 3'd5;
    localparam logic [IDX_W-1:0] REG_ESI = 3'd6;
    localparam logic [IDX_W-1:0] REG_EDI = 3'd7;

    // Component/revision ID presented in EDX after reset.
    localparam logic [DATA_W-1:0] RESET_EDX_DEFAULT = 32'h0000_0308;

    // Decoded access: target register, lanes touched, and lane alignment.
    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [DATA_W-1:0]  mask;
        logic [SHIFT_W-1:0] shift;
        logic               rsvd;
    } lane_sel_t;

endpackage

// File: rtl/general_register_lane_select.sv
// Maps a register-sequence code plus operand size to register index,
// lane mask and lane shift. Shared by the write port and both read ports.
module general_register_lane_select
    import general_register_file_pkg::*;
(
    input  logic [IDX_W-1:0]  code,
    input  logic [SIZE_W-1:0] size,
    output lane_sel_t         sel_c
);

    size_e size_dec;

    // Byte codes 4-7 address the high byte of registers 0-3, never 4-7.
    always_comb begin
        size_dec    = size_e'(size);
        sel_c.idx   = code;
        sel_c.mask  = '0;
        sel_c.shift = '0;
        sel_c.rsvd  = 1'b0;
        case (size_dec)
            SIZE_BYTE: begin
                sel_c.idx = {1'b0, code[1:0]};
                if (code[2]) begin
                    sel_c.mask  = 32'h0000_FF00;
                    sel_c.shift = SHIFT_W'(8);
                end else begin
                    sel_c.mask  = 32'h0000_00FF;
                end
            end
            SIZE_WORD:  sel_c.mask = 32'h0000_FFFF;
            SIZE_DWORD: sel_c.mask = 32'hFFFF_FFFF;
            default:    sel_c.rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/general_register_file.sv
// Architectural GPR file: two combinational write-first read ports,
// one lane-merging write port and an ESP adjust port for push/pop.
module general_register_file
    import general_register_file_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_EDX = RESET_EDX_DEFAULT
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd0_code,
    input  logic [SIZE_W-1:0]   rd0_size,
    output logic [DATA_W-1:0]   rd0_data,
    input  logic [IDX_W-1:0]    rd1_code,
    input  logic [SIZE_W-1:0]   rd1_size,
    output logic [DATA_W-1:0]   rd1_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_code,
    input  logic [SIZE_W-1:0]   wr_size,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                esp_adj_en,
    input  logic [DATA_W-1:0]   esp_adj_delta,
    output logic                esp_conflict,
    output logic                size_error
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    lane_sel_t         wr_sel;
    lane_sel_t         rd0_sel;
    lane_sel_t         rd1_sel;

    logic [DATA_W-1:0] wr_merged_c;
    logic              wr_active_c;
    logic              esp_hit_c;
    logic [DATA_W-1:0] esp_sum_c;
    logic [DATA_W-1:0] rd0_src_c;
    logic [DATA_W-1:0] rd1_src_c;

    general_register_lane_select u_wr_sel (
        .code  (wr_code),
        .size  (wr_size),
        .sel_c (wr_sel)
    );

    general_register_lane_select u_rd0_sel (
        .code  (rd0_code),
        .size  (rd0_size),
        .sel_c (rd0_sel)
    );

    general_register_lane_select u_rd1_sel (
        .code  (rd1_code),
        .size  (rd1_size),
        .sel_c (rd1_sel)
    );

    // Post-merge value of the write target; also feeds the read bypass.
    always_comb begin
        wr_active_c = wr_en && !wr_sel.rsvd;
        wr_merged_c = (regs[wr_sel.idx] & ~wr_sel.mask)
                    | ((wr_data << wr_sel.shift) & wr_sel.mask);
        esp_hit_c   = wr_active_c && (wr_sel.idx == REG_ESP);
        esp_sum_c   = regs[REG_ESP] + esp_adj_delta;
    end

    // Read port 0: write-first bypass, then right-align selected lanes.
    always_comb begin
        rd0_src_c = regs[rd0_sel.idx];
        if (wr_active_c && (rd0_sel.idx == wr_sel.idx)) begin
            rd0_src_c = wr_merged_c;
        end
        rd0_data = (rd0_src_c & rd0_sel.mask) >> rd0_sel.shift;
    end

    // Read port 1: same structure as port 0.
    always_comb begin
        rd1_src_c = regs[rd1_sel.idx];
        if (wr_active_c && (rd1_sel.idx == wr_sel.idx)) begin
            rd1_src_c = wr_merged_c;
        end
        rd1_data = (rd1_src_c & rd1_sel.mask) >> rd1_sel.shift;
    end

    // Register array: explicit write wins over an ESP adjust to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= (IDX_W'(i) == REG_EDX) ? RESET_EDX : '0;
            end
        end else begin
            if (wr_active_c) begin
                regs[wr_sel.idx] <= wr_merged_c;
            end
            if (esp_adj_en && !esp_hit_c) begin
                regs[REG_ESP] <= esp_sum_c;
            end
        end
    end

    // One-cycle status flags, recomputed every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            esp_conflict <= 1'b0;
            size_error   <= 1'b0;
        end else begin
            esp_conflict <= esp_hit_c && esp_adj_en;
            size_error   <= (wr_en && wr_sel.rsvd) || rd0_sel.rsvd || rd1_sel.rsvd;
        end
    end

endmodule

// File: tb/tb_general_register_file.sv
// Scoreboard bench for general_register_file.
module tb_general_register_file;

    logic        clk;
    logic        rst;
    logic [2:0]  rd0_code;
    logic [1:0]  rd0_size;
    logic [31:0] rd0_data;
    logic [2:0]  rd1_code;
    logic [1:0]  rd1_size;
    logic [31:0] rd1_data;
    logic        wr_en;
    logic [2:0]  wr_code;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic        esp_adj_en;
    logic [31:0] esp_adj_delta;
    logic        esp_conflict;
    logic        size_error;

    general_register_file dut (
        .clk           (clk),
        .rst           (rst),
        .rd0_code      (rd0_code),
        .rd0_size      (rd0_size),
        .rd0_data      (rd0_data),
        .rd1_code      (rd1_code),
        .rd1_size      (rd1_size),
        .rd1_data      (rd1_data),
        .wr_en         (wr_en),
        .wr_code       (wr_code),
        .wr_size       (wr_size),
        .wr_data       (wr_data),
        .esp_adj_en    (esp_adj_en),
        .esp_adj_delta (esp_adj_delta),
        .esp_conflict  (esp_conflict),
        .size_error    (size_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_err;
    logic [31:0] mreg [8];
    logic [31:0] post [8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_check(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, got, e.exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
        mreg[2] = 32'h0000_0308;
    endfunction

    // Reads from the post-write image (write-first).
    function automatic logic [31:0] model_read(input logic [2:0] code, input logic [1:0] size);
        logic [31:0] r;
        case (size)
            2'd0: r = (code < 3'd4) ? {24'h0, post[code][7:0]} : {24'h0, post[code - 3'd4][15:8]};
            2'd1: r = {16'h0, post[code][15:0]};
            2'd2: r = post[code];
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic step(input logic [2:0] r0c, input logic [1:0] r0s,
                        input logic [2:0] r1c, input logic [1:0] r1s,
                        input logic we, input logic [2:0] wc, input logic [1:0] ws,
                        input logic [31:0] wd, input logic ae, input logic [31:0] ad);
        logic conf;
        logic serr;
        @(negedge clk);
        rd0_code = r0c; rd0_size = r0s; rd1_code = r1c; rd1_size = r1s;
        wr_en = we; wr_code = wc; wr_size = ws; wr_data = wd;
        esp_adj_en = ae; esp_adj_delta = ad;
        for (int i = 0; i < 8; i++) post[i] = mreg[i];
        if (we) begin
            case (ws)
                2'd0: if (wc < 3'd4) post[wc][7:0] = wd[7:0];
                      else post[wc - 3'd4][15:8] = wd[7:0];
                2'd1: post[wc][15:0] = wd[15:0];
                2'd2: post[wc] = wd;
                default: ;
            endcase
        end
        conf = we && ae && (wc == 3'd4) && (ws == 2'd1 || ws == 2'd2);
        serr = (we && ws == 2'd3) || (r0s == 2'd3) || (r1s == 2'd3);
        sb_push($sformatf("rd0 c%0d s%0d", r0c, r0s), model_read(r0c, r0s));
        sb_push($sformatf("rd1 c%0d s%0d", r1c, r1s), model_read(r1c, r1s));
        sb_push("esp_conflict", {31'h0, conf});
        sb_push("size_error", {31'h0, serr});
        #2;
        sb_check(rd0_data);
        sb_check(rd1_data);
        @(posedge clk);
        for (int i = 0; i < 8; i++) mreg[i] = post[i];
        if (ae && !conf) mreg[4] = mreg[4] + ad;
        #1;
        sb_check({31'h0, esp_conflict});
        sb_check({31'h0, size_error});
    endtask

    task automatic rd(input logic [2:0] c0, input logic [1:0] s0, input logic [2:0] c1, input logic [1:0] s1);
        step(c0, s0, c1, s1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] wc, input logic [1:0] ws, input logic [31:0] wd,
                      input logic [2:0] c0, input logic [1:0] s0, input logic [2:0] c1, input logic [1:0] s1);
        step(c0, s0, c1, s1, 1'b1, wc, ws, wd, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat;
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        rd0_code = 0; rd0_size = 0; rd1_code = 0; rd1_size = 0;
        wr_en = 0; wr_code = 0; wr_size = 0; wr_data = 0;
        esp_adj_en = 0; esp_adj_delta = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst esp_conflict", {31'h0, esp_conflict}, 32'h0);
        check_val("rst size_error", {31'h0, size_error}, 32'h0);
        rst = 1'b0;

        // Reset values of all eight registers.
        for (int i = 0; i < 4; i++) rd(3'(2 * i), 2'd2, 3'(2 * i + 1), 2'd2);

        // Lane merge through EAX.
        wr(3'd0, 2'd2, 32'h1122_3344, 3'd0, 2'd2, 3'd0, 2'd0);
        wr(3'd4, 2'd0, 32'h0000_00AA, 3'd4, 2'd0, 3'd0, 2'd2);
        rd(3'd4, 2'd0, 3'd0, 2'd2);
        wr(3'd0, 2'd1, 32'h0000_5566, 3'd0, 2'd2, 3'd0, 2'd1);
        rd(3'd4, 2'd0, 3'd0, 2'd2);

        // Same-cycle bypass into CH and ECX.
        wr(3'd1, 2'd2, 32'hDEAD_BEEF, 3'd5, 2'd0, 3'd1, 2'd2);

        // ESP wrap, then explicit write colliding with an adjust.
        wr(3'd4, 2'd2, 32'h0000_0002, 3'd4, 2'd2, 3'd4, 2'd1);
        step(3'd4, 2'd2, 3'd0, 2'd2, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        rd(3'd4, 2'd2, 3'd4, 2'd1);
        step(3'd4, 2'd2, 3'd4, 2'd0, 1'b1, 3'd4, 2'd2, 32'h0000_0100, 1'b1, 32'h0000_0004);
        rd(3'd4, 2'd2, 3'd0, 2'd2);
        // AH write alongside an adjust never conflicts.
        step(3'd4, 2'd0, 3'd4, 2'd2, 1'b1, 3'd4, 2'd0, 32'h0000_0077, 1'b1, 32'h0000_0010);
        rd(3'd4, 2'd2, 3'd0, 2'd2);

        // Reserved sizes.
        wr(3'd0, 2'd3, 32'hFFFF_FFFF, 3'd0, 2'd2, 3'd1, 2'd2);
        rd(3'd0, 2'd3, 3'd0, 2'd2);
        rd(3'd1, 2'd2, 3'd2, 2'd3);
        rd(3'd0, 2'd2, 3'd1, 2'd2);

        // Sweep of size x code with read-back at every size.
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 8; c++) begin
                pat = 32'h9C00_0000 ^ (32'(c + 1) * 32'h0101_0101) ^ (32'(s) * 32'h0035_7A00);
                wr(3'(c), 2'(s), pat, 3'(c), 2'd0, 3'(c), 2'd1);
                rd(3'(c), 2'd2, 3'(c ^ 4), 2'd0);
            end
        end

        // Randomised traffic including reserved sizes and adjusts.
        for (int n = 0; n < 200; n++) begin
            step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom(), 1'($urandom_range(0, 1)), $urandom());
        end

        // Asynchronous reset mid-stream; the coinciding write and adjust are lost.
        wr(3'd1, 2'd2, 32'h1357_9BDF, 3'd1, 2'd2, 3'd0, 2'd2);
        @(negedge clk);
        rd0_code = 3'd1; rd0_size = 2'd2; rd1_code = 3'd2; rd1_size = 2'd2;
        wr_en = 1'b1; wr_code = 3'd0; wr_size = 2'd2; wr_data = 32'h1234_5678;
        esp_adj_en = 1'b1; esp_adj_delta = 32'h5;
        #2 rst = 1'b1;
        #1;
        check_val("async rst ECX", rd0_data, 32'h0);
        check_val("async rst EDX", rd1_data, 32'h0000_0308);
        @(posedge clk);
        #1;
        check_val("rst esp_conflict hold", {31'h0, esp_conflict}, 32'h0);
        check_val("rst size_error hold", {31'h0, size_error}, 32'h0);
        @(negedge clk);
        wr_en = 1'b0; esp_adj_en = 1'b0;
        rd0_code = 3'd0; rd1_code = 3'd4;
        #1;
        check_val("rst lost write EAX", rd0_data, 32'h0);
        check_val("rst lost adjust ESP", rd1_data, 32'h0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) rd(3'(2 * i), 2'd2, 3'(2 * i + 1), 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
